jzjpcc_memory_stage: RTL and testbench
======================================

# jzjpcc_memory_stage

Memory stage of the jzjpcc pipeline: takes an executed instruction, issues load/store requests to synchronous data memory, and drives the writeback stage through `jzjpcc_writeback_if.memory`. It performs store-side byte-lane placement (the inverse of writeback's load extraction) and generates the byte mask that writeback uses to select load data. It also detects misaligned accesses. It is the only producer on the writeback interface.

## Interface
Parameters:
- none. The architecture is fixed at RV32, with 32-bit data and 4 byte lanes.

Ports:
- `clock`  in  1  pipeline clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `valid_memory`  in  1  execute-stage output holds a real instruction.
- `isLoad_memory`, `isStore_memory`  in  1 each  access type; never both high.
- `aluResult_memory`  in  32  byte address for loads/stores, or the ALU result.
- `rs2_memory`  in  32  store data, architectural little-endian value.
- `funct3_memory`  in  3  load/store width code.
- `rdAddr_memory`, `rdWriteEnable_memory`, `rdSource_memory`  in  5/1/1  forwarded to writeback.
- `stall`  in  1  hold this stage; upstream holds its outputs.
- `flush`  in  1  squash the instruction currently in this stage.
- `memWordAddr`  out  30  equals `aluResult_memory[31:2]`.
- `memReadEnable`  out  1  memory read request.
- `memWriteEnable`  out  1  memory write request.
- `memByteEnable`  out  4  byte lanes written.
- `memWriteData`  out  32  lane-placed store data.
- `memReadData`  in  32  raw registered memory output, valid the cycle after a read.
- `writebackIF`  `jzjpcc_writeback_if.memory`  –  outputs to writeback.
- `misaligned`  out  1  one-cycle pulse after a misaligned access.
- `badAddr`  out  32  address of the most recent misaligned access.

## Operation
- Lane mapping (big-endian word storage):
  - Byte offset k (`addr[1:0]`) maps to lane 3-k; lane 3 is bits [31:24].
  - Byte masks: `1000`/`0100`/`0010`/`0001` for offsets 0/1/2/3.
  - Halfword masks: `1100` for offset 0, `0011` for offset 2.
  - Word mask: `1111`.
- Store data placement:
  - sb: `rs2[7:0]` is replicated into all lanes; the mask selects the lane.
  - sh: the lane holding the lower address gets `rs2[7:0]`, the next lane gets `rs2[15:8]`.
  - sw: the full byte swap of `rs2`.
- Misalignment rules:
  - Halfword with `addr[0]`=1 is misaligned.
  - Word with `addr[1:0]`≠0 is misaligned.
  - Unused funct3 codes (011, 110, 111) are treated as misaligned.
- Combinational request, with `go = valid & ~stall & ~flush & aligned`:
  - `memReadEnable = go & isLoad`.
  - `memWriteEnable = go & isStore`.
  - `memByteEnable` is always the computed mask; it is 0 for non-memory ops.
- Memory holds its output register while `memReadEnable`=0. A stalled load therefore keeps its data valid.
- Writeback pipeline register, updated each edge unless `stall`:
  - Captures rdAddr, rdSource, aluResult, funct3 and memByteMask.
  - Captures `rdWriteEnable = valid & rdWriteEnable & ~flush & ~(misaligned memory op)`.
- `writebackIF.memoryOut` is `memReadData` passed through combinationally, with no register.
- Misalignment register:
  - `misaligned` is registered high for one cycle when `valid & ~stall & ~flush` and the memory op is misaligned.
  - `badAddr` latches `aluResult` in that same cycle and holds until the next misalignment.
- Priority: `flush` squashes both the memory request and the writeback capture. `stall` overrides the register update. With flush and stall both high, registers hold, and the held content must not be re-issued.

## Timing
- Memory request is issued in cycle N. Writeback fields become valid after the edge ending N. `memoryOut` is valid during cycle N+1.
- Latency: 1 cycle from memory-stage input to writeback-interface output.
- A store commits at the edge ending N and is issued exactly once, even across stalls.
- Reset, asynchronous assert:
  - All writeback register outputs 0, including `rdWriteEnable`=0, `rdSource`=0 and `memByteMask`=0.
  - `misaligned`=0 and `badAddr`=0.
- Release is synchronous to `clock`.
- Reset mid-stall discards the held instruction.
- A misaligned op produces no memory request and no register write. The `misaligned` pulse is not extended by stall; it lasts one cycle only.

## Structure
- Lane-mask and alignment helpers go in a shared `jzjpcc_memory_functions` package, alongside `jzjpcc_endianness_functions`. Funct3 width constants also go there.
- Store placement reuses `toBigEndian32`/`toBigEndian16`.
- One sub-module: `jzjpcc_store_aligner`, combinational, mapping funct3/addr/rs2 to data, mask and misaligned.
- Target size: about 200 lines.

## Test plan
- sb, addr 0x1003, rs2 0xAB: `memWordAddr`=0x400, `memByteEnable`=0001, `memWriteData[7:0]`=0xAB; next cycle `memByteMask`=0001.
- sh, addr 0x1002, rs2 0x1234: enable 0011, `memWriteData[15:0]`=0x3412.
- sw, addr 0x1000, rs2 0x11223344: enable 1111, data 0x44332211. Then lw at the same address with `memReadData`=0x44332211: `memoryOut`=0x44332211 and `rdWriteEnable`=1 in N+1.
- lw, addr 0x1001: no request; next cycle `misaligned`=1, `badAddr`=0x1001, writeback `rdWriteEnable`=0.
- Store held under `stall` for 3 cycles: `memWriteEnable` high only in the release cycle. A flush during the final cycle gives zero writes and a bubble.
- Reset asserted mid-load: all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/jzjpcc_endianness_functions.sv
// Byte-order helpers shared by the memory and writeback stages.
package jzjpcc_endianness_functions;

  function automatic logic [31:0] toBigEndian32(input logic [31:0] value);
    return {value[7:0], value[15:8], value[23:16], value[31:24]};
  endfunction

  function automatic logic [15:0] toBigEndian16(input logic [15:0] value);
    return {value[7:0], value[15:8]};
  endfunction

endpackage

// File: rtl/jzjpcc_memory_functions.sv
// Access-width decoding, lane masks and alignment rules for RV32 loads/stores.
package jzjpcc_memory_functions;

  localparam logic [2:0] FUNCT3_BYTE   = 3'b000;
  localparam logic [2:0] FUNCT3_HALF   = 3'b001;
  localparam logic [2:0] FUNCT3_WORD   = 3'b010;
  localparam logic [2:0] FUNCT3_BYTE_U = 3'b100;
  localparam logic [2:0] FUNCT3_HALF_U = 3'b101;

  typedef enum logic [1:0] {
    WIDTH_BYTE,
    WIDTH_HALF,
    WIDTH_WORD,
    WIDTH_NONE
  } accessWidth_t;

  function automatic accessWidth_t decodeWidth(input logic [2:0] funct3);
    case (funct3)
      FUNCT3_BYTE, FUNCT3_BYTE_U: return WIDTH_BYTE;
      FUNCT3_HALF, FUNCT3_HALF_U: return WIDTH_HALF;
      FUNCT3_WORD:                return WIDTH_WORD;
      default:                    return WIDTH_NONE;
    endcase
  endfunction

  // Offset k lives in lane 3-k (lane 3 = bits [31:24]).
  function automatic logic [3:0] laneMask(input accessWidth_t width, input logic [1:0] offset);
    case (width)
      WIDTH_BYTE: return 4'b1000 >> offset;
      WIDTH_HALF: return offset[1] ? 4'b0011 : 4'b1100;
      WIDTH_WORD: return 4'b1111;
      default:    return 4'b0000;
    endcase
  endfunction

  function automatic logic isMisaligned(input accessWidth_t width, input logic [1:0] offset);
    case (width)
      WIDTH_BYTE: return 1'b0;
      WIDTH_HALF: return offset[0];
      WIDTH_WORD: return offset != 2'b00;
      default:    return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/jzjpcc_writeback_if.sv
// Memory-to-writeback pipeline interface; the memory stage is its only producer.
interface jzjpcc_writeback_if;
  logic [4:0]  rdAddr;
  logic        rdWriteEnable;
  logic        rdSource;
  logic [31:0] aluResult;
  logic [2:0]  funct3;
  logic [3:0]  memByteMask;
  logic [31:0] memoryOut;

  modport memory (
    output rdAddr, rdWriteEnable, rdSource, aluResult, funct3, memByteMask, memoryOut
  );

  modport writeback (
    input rdAddr, rdWriteEnable, rdSource, aluResult, funct3, memByteMask, memoryOut
  );
endinterface

// File: rtl/jzjpcc_store_aligner.sv
// Combinational store lane placement, byte mask and misalignment detection.
module jzjpcc_store_aligner
  import jzjpcc_endianness_functions::*;
  import jzjpcc_memory_functions::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byteOffset,
  input  logic [31:0] rs2,
  output logic [31:0] storeData,
  output logic [3:0]  byteMask,
  output logic        misaligned
);

  accessWidth_t width;

  always_comb begin
    width      = decodeWidth(funct3);
    byteMask   = laneMask(width, byteOffset);
    misaligned = isMisaligned(width, byteOffset);
    storeData  = '0;
    case (width)
      WIDTH_BYTE: storeData = {4{rs2[7:0]}};
      WIDTH_HALF: storeData = {2{toBigEndian16(rs2[15:0])}};
      WIDTH_WORD: storeData = toBigEndian32(rs2);
      default:    storeData = '0;
    endcase
  end

endmodule

// File: rtl/jzjpcc_memory_stage.sv
// Memory stage: issues data-memory requests, flags misaligned accesses and
// registers the instruction into the writeback interface.
module jzjpcc_memory_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic        valid_memory,
  input  logic        isLoad_memory,
  input  logic        isStore_memory,
  input  logic [31:0] aluResult_memory,
  input  logic [31:0] rs2_memory,
  input  logic [2:0]  funct3_memory,
  input  logic [4:0]  rdAddr_memory,
  input  logic        rdWriteEnable_memory,
  input  logic        rdSource_memory,
  input  logic        stall,
  input  logic        flush,
  output logic [29:0] memWordAddr,
  output logic        memReadEnable,
  output logic        memWriteEnable,
  output logic [3:0]  memByteEnable,
  output logic [31:0] memWriteData,
  input  logic [31:0] memReadData,
  jzjpcc_writeback_if.memory writebackIF,
  output logic        misaligned,
  output logic [31:0] badAddr
);

  logic [31:0] storeData;
  logic [3:0]  accessMask;
  logic        accessMisaligned;
  logic        isMemOp;
  logic        memMisaligned;
  logic        live;
  logic        go;

  logic [4:0]  rdAddrReg;
  logic        rdWriteEnableReg;
  logic        rdSourceReg;
  logic [31:0] aluResultReg;
  logic [2:0]  funct3Reg;
  logic [3:0]  memByteMaskReg;

  jzjpcc_store_aligner storeAligner (
    .funct3     (funct3_memory),
    .byteOffset (aluResult_memory[1:0]),
    .rs2        (rs2_memory),
    .storeData  (storeData),
    .byteMask   (accessMask),
    .misaligned (accessMisaligned)
  );

  // Requests are also gated by reset so nothing reaches memory while it is held.
  always_comb begin
    isMemOp        = isLoad_memory | isStore_memory;
    memMisaligned  = isMemOp & accessMisaligned;
    live           = valid_memory & ~stall & ~flush;
    go             = live & ~memMisaligned & reset;
    memWordAddr    = aluResult_memory[31:2];
    memReadEnable  = go & isLoad_memory;
    memWriteEnable = go & isStore_memory;
    memByteEnable  = isMemOp ? accessMask : '0;
    memWriteData   = storeData;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rdAddrReg        <= '0;
      rdWriteEnableReg <= 1'b0;
      rdSourceReg      <= 1'b0;
      aluResultReg     <= '0;
      funct3Reg        <= '0;
      memByteMaskReg   <= '0;
    end else if (!stall) begin
      rdAddrReg        <= rdAddr_memory;
      rdWriteEnableReg <= valid_memory & rdWriteEnable_memory & ~flush & ~memMisaligned;
      rdSourceReg      <= rdSource_memory;
      aluResultReg     <= aluResult_memory;
      funct3Reg        <= funct3_memory;
      memByteMaskReg   <= memByteEnable;
    end
  end

  // The pulse is recomputed every edge, so a stall can never stretch it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      misaligned <= 1'b0;
      badAddr    <= '0;
    end else begin
      misaligned <= live & memMisaligned;
      if (live & memMisaligned) badAddr <= aluResult_memory;
    end
  end

  assign writebackIF.rdAddr        = rdAddrReg;
  assign writebackIF.rdWriteEnable = rdWriteEnableReg;
  assign writebackIF.rdSource      = rdSourceReg;
  assign writebackIF.aluResult     = aluResultReg;
  assign writebackIF.funct3        = funct3Reg;
  assign writebackIF.memByteMask   = memByteMaskReg;
  assign writebackIF.memoryOut     = memReadData;

endmodule

// File: tb/tb_jzjpcc_memory_stage.sv
// Scoreboard bench for jzjpcc_memory_stage: request outputs checked mid-cycle,
// writeback/misalignment registers popped from a queue after each edge.
module tb_jzjpcc_memory_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        valid_memory = 1'b0;
  logic        isLoad_memory = 1'b0;
  logic        isStore_memory = 1'b0;
  logic [31:0] aluResult_memory = '0;
  logic [31:0] rs2_memory = '0;
  logic [2:0]  funct3_memory = '0;
  logic [4:0]  rdAddr_memory = '0;
  logic        rdWriteEnable_memory = 1'b0;
  logic        rdSource_memory = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [29:0] memWordAddr;
  logic        memReadEnable;
  logic        memWriteEnable;
  logic [3:0]  memByteEnable;
  logic [31:0] memWriteData;
  logic [31:0] memReadData = '0;
  logic        misaligned;
  logic [31:0] badAddr;

  jzjpcc_writeback_if wbIf ();

  jzjpcc_memory_stage dut (
    .clock                (clock),
    .reset                (reset),
    .valid_memory         (valid_memory),
    .isLoad_memory        (isLoad_memory),
    .isStore_memory       (isStore_memory),
    .aluResult_memory     (aluResult_memory),
    .rs2_memory           (rs2_memory),
    .funct3_memory        (funct3_memory),
    .rdAddr_memory        (rdAddr_memory),
    .rdWriteEnable_memory (rdWriteEnable_memory),
    .rdSource_memory      (rdSource_memory),
    .stall                (stall),
    .flush                (flush),
    .memWordAddr          (memWordAddr),
    .memReadEnable        (memReadEnable),
    .memWriteEnable       (memWriteEnable),
    .memByteEnable        (memByteEnable),
    .memWriteData         (memWriteData),
    .memReadData          (memReadData),
    .writebackIF          (wbIf),
    .misaligned           (misaligned),
    .badAddr              (badAddr)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  rdAddr;
    logic        rdWe;
    logic        rdSrc;
    logic [31:0] alu;
    logic [2:0]  f3;
    logic [3:0]  mask;
    logic        maskKnown;
    logic        mis;
    logic [31:0] bad;
  } regExp_t;

  regExp_t     model;
  regExp_t     scoreboard[$];
  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned writeCount = 0;

  task automatic checkValue(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [3:0] refMask(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      3'b000, 3'b100: return 4'b1000 >> off;
      3'b001, 3'b101: return 4'b1100 >> off;
      3'b010:         return 4'b1111;
      default:        return 4'b0000;
    endcase
  endfunction

  function automatic logic refMisaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      3'b000, 3'b100: return 1'b0;
      3'b001, 3'b101: return off[0];
      3'b010:         return off != 2'b00;
      default:        return 1'b1;
    endcase
  endfunction

  // Address offset k lands in lane 3-k and takes byte (k - base) of rs2.
  function automatic logic [31:0] refStoreData(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] rs2);
    logic [31:0] d;
    logic [3:0]  m;
    int          base;
    d    = '0;
    m    = refMask(f3, off);
    base = int'(off);
    for (int k = 0; k < 4; k++)
      if (m[3-k]) d[8*(3-k) +: 8] = rs2[8*(k-base) +: 8];
    return d;
  endfunction

  function automatic logic [31:0] expandMask(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

  task automatic step(input logic v, input logic ld, input logic st, input logic [31:0] addr,
                      input logic [31:0] data, input logic [2:0] f3, input logic [4:0] rd,
                      input logic rdWe, input logic rdSrc, input logic stl, input logic fl,
                      input logic [31:0] rdData, input string tag);
    logic    mem, mis, live, go;
    logic [3:0] em;
    regExp_t nxt, got;
    valid_memory = v; isLoad_memory = ld; isStore_memory = st;
    aluResult_memory = addr; rs2_memory = data; funct3_memory = f3;
    rdAddr_memory = rd; rdWriteEnable_memory = rdWe; rdSource_memory = rdSrc;
    stall = stl; flush = fl; memReadData = rdData;
    #3;
    mem  = ld | st;
    mis  = mem & refMisaligned(f3, addr[1:0]);
    live = v & ~stl & ~fl;
    go   = live & ~mis;
    em   = mem ? refMask(f3, addr[1:0]) : 4'b0000;
    if (memWriteEnable === 1'b1) writeCount++;
    checkValue({tag, ".wordAddr"}, {2'b00, memWordAddr}, {2'b00, addr[31:2]});
    checkValue({tag, ".readEn"}, {31'd0, memReadEnable}, {31'd0, go & ld});
    checkValue({tag, ".writeEn"}, {31'd0, memWriteEnable}, {31'd0, go & st});
    if (!mis) checkValue({tag, ".byteEn"}, {28'd0, memByteEnable}, {28'd0, em});
    if (st && !mis)
      checkValue({tag, ".writeData"}, memWriteData & expandMask(em), refStoreData(f3, addr[1:0], data));
    checkValue({tag, ".memoryOut"}, wbIf.memoryOut, rdData);

    nxt     = model;
    nxt.mis = live & mis;
    if (live & mis) nxt.bad = addr;
    if (!stl) begin
      nxt.rdAddr    = rd;
      nxt.rdWe      = v & rdWe & ~fl & ~mis;
      nxt.rdSrc     = rdSrc;
      nxt.alu       = addr;
      nxt.f3        = f3;
      nxt.mask      = em;
      nxt.maskKnown = ~mis;
    end
    model = nxt;
    scoreboard.push_back(nxt);

    @(posedge clock);
    #1;
    got = scoreboard.pop_front();
    checkValue({tag, ".wb.rdAddr"}, {27'd0, wbIf.rdAddr}, {27'd0, got.rdAddr});
    checkValue({tag, ".wb.rdWe"}, {31'd0, wbIf.rdWriteEnable}, {31'd0, got.rdWe});
    checkValue({tag, ".wb.rdSrc"}, {31'd0, wbIf.rdSource}, {31'd0, got.rdSrc});
    checkValue({tag, ".wb.alu"}, wbIf.aluResult, got.alu);
    checkValue({tag, ".wb.funct3"}, {29'd0, wbIf.funct3}, {29'd0, got.f3});
    if (got.maskKnown)
      checkValue({tag, ".wb.mask"}, {28'd0, wbIf.memByteMask}, {28'd0, got.mask});
    checkValue({tag, ".misaligned"}, {31'd0, misaligned}, {31'd0, got.mis});
    checkValue({tag, ".badAddr"}, badAddr, got.bad);
  endtask

  task automatic idle(input logic [31:0] rdData, input string tag);
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, rdData, tag);
  endtask

  task automatic checkRegsZero(input string tag);
    checkValue({tag, ".rdAddr"}, {27'd0, wbIf.rdAddr}, 32'h0);
    checkValue({tag, ".rdWe"}, {31'd0, wbIf.rdWriteEnable}, 32'h0);
    checkValue({tag, ".rdSrc"}, {31'd0, wbIf.rdSource}, 32'h0);
    checkValue({tag, ".alu"}, wbIf.aluResult, 32'h0);
    checkValue({tag, ".funct3"}, {29'd0, wbIf.funct3}, 32'h0);
    checkValue({tag, ".mask"}, {28'd0, wbIf.memByteMask}, 32'h0);
    checkValue({tag, ".misaligned"}, {31'd0, misaligned}, 32'h0);
    checkValue({tag, ".badAddr"}, badAddr, 32'h0);
    checkValue({tag, ".readEn"}, {31'd0, memReadEnable}, 32'h0);
    checkValue({tag, ".writeEn"}, {31'd0, memWriteEnable}, 32'h0);
  endtask

  task automatic clearModel();
    model = '{rdAddr: '0, rdWe: 1'b0, rdSrc: 1'b0, alu: '0, f3: '0, mask: '0,
              maskKnown: 1'b1, mis: 1'b0, bad: '0};
    scoreboard.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench did not complete");
  end

  initial begin
    logic [31:0] a, d;
    logic [2:0]  f;
    int unsigned op;

    clearModel();
    #1 reset = 1'b0;
    #1 checkRegsZero("reset");
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b1;

    step(1, 0, 1, 32'h0000_1003, 32'h0000_00AB, 3'b000, 5'd0, 0, 0, 0, 0, 32'h0, "sb");
    step(1, 0, 1, 32'h0000_1002, 32'h0000_1234, 3'b001, 5'd0, 0, 0, 0, 0, 32'h0, "sh");
    step(1, 0, 1, 32'h0000_1000, 32'h1122_3344, 3'b010, 5'd0, 0, 0, 0, 0, 32'h0, "sw");
    step(1, 1, 0, 32'h0000_1000, 32'h0, 3'b010, 5'd5, 1, 1, 0, 0, 32'h0, "lw");
    idle(32'h4433_2211, "lwData");
    step(1, 1, 0, 32'h0000_1001, 32'h0, 3'b010, 5'd6, 1, 1, 0, 0, 32'h0, "lwMis");
    idle(32'h0, "afterMis");
    step(1, 0, 1, 32'h0000_2001, 32'h0000_BEEF, 3'b001, 5'd0, 0, 0, 0, 0, 32'h0, "shMis");
    step(1, 1, 0, 32'h0000_2000, 32'h0, 3'b011, 5'd7, 1, 1, 0, 0, 32'h0, "badFunct3");
    step(1, 1, 0, 32'h0000_2002, 32'h0, 3'b101, 5'd8, 1, 1, 0, 0, 32'h0, "lhu");
    step(1, 0, 0, 32'hDEAD_BEEF, 32'h0, 3'b111, 5'd9, 1, 0, 0, 0, 32'h0, "aluOp");

    writeCount = 0;
    for (int i = 0; i < 3; i++)
      step(1, 0, 1, 32'h0000_3000, 32'hCAFE_F00D, 3'b010, 5'd0, 0, 0, 1, 0, 32'h0, "swStall");
    step(1, 0, 1, 32'h0000_3000, 32'hCAFE_F00D, 3'b010, 5'd0, 0, 0, 0, 0, 32'h0, "swRelease");
    checkValue("swStall.writes", writeCount, 32'd1);

    writeCount = 0;
    step(1, 0, 1, 32'h0000_3004, 32'h5555_AAAA, 3'b010, 5'd0, 0, 0, 1, 0, 32'h0, "swStallF");
    step(1, 0, 1, 32'h0000_3004, 32'h5555_AAAA, 3'b010, 5'd0, 0, 0, 1, 1, 32'h0, "swStallBoth");
    step(1, 0, 1, 32'h0000_3004, 32'h5555_AAAA, 3'b010, 5'd1, 1, 0, 0, 1, 32'h0, "swFlush");
    checkValue("swFlush.writes", writeCount, 32'd0);

    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 2);
      a  = $urandom;
      d  = $urandom;
      f  = (op == 2) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
      step(1'($urandom_range(0, 3) != 0), op == 1, op == 2, a, d, f, 5'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 6) == 0), $urandom, "rand");
    end

    step(1, 1, 0, 32'h0000_4001, 32'h0, 3'b010, 5'd3, 1, 1, 0, 0, 32'h0, "preResetMis");
    step(1, 1, 0, 32'h0000_4000, 32'h0, 3'b010, 5'd4, 1, 1, 0, 0, 32'h0, "preResetLw");
    valid_memory = 1'b1; isLoad_memory = 1'b1; isStore_memory = 1'b0;
    aluResult_memory = 32'h0000_4008; funct3_memory = 3'b010;
    rdAddr_memory = 5'd10; rdWriteEnable_memory = 1'b1; stall = 1'b1; flush = 1'b0;
    #2 reset = 1'b0;
    #1 checkRegsZero("midReset");
    clearModel();
    @(posedge clock); #1;
    reset = 1'b1;
    idle(32'h0, "postReset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
